// File: rtl/seq_detect.sv
//------------------------------------------------------------------------------
// Module      : seq_detect
// Description : Parametrised serial pattern detector with a registered match
//               pulse and an optional saturating match counter, built in when
//               SEQ_DETECT_COUNT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detect #(
  parameter int unsigned        PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned          c_fill_w   = $clog2(PAT_LEN + 1);
  localparam logic [c_fill_w-1:0]  c_fill_max = c_fill_w'(PAT_LEN);
  localparam logic [c_fill_w-1:0]  c_fill_thr = c_fill_w'(PAT_LEN - 1);

  logic [PAT_LEN-1:0]  r_sr;
  logic [c_fill_w-1:0] r_fill;
  logic                r_y;

  logic [PAT_LEN-1:0]  w_nxt;
  logic                w_hit;
  logic [c_fill_w-1:0] w_fill_nxt;

  assign w_nxt = {r_sr[PAT_LEN-2:0], x};
  // The fill gate keeps reset-zeroed bits from ever completing a match.
  assign w_hit = en && (r_fill >= c_fill_thr) && (w_nxt == PATTERN);

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_hit) begin
      w_fill_nxt = overlap ? c_fill_max : '0;
    end else if (r_fill != c_fill_max) begin
      w_fill_nxt = r_fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (en) begin
      r_sr   <= w_nxt;
      r_fill <= w_fill_nxt;
      r_y    <= w_hit;
    end else begin
      r_y    <= 1'b0;
    end
  end

  assign y = r_y;

`ifdef SEQ_DETECT_COUNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_match_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_count <= '0;
    end else if (count_clr) begin
      // A hit coincident with the clear is still counted.
      r_match_count <= w_hit ? c_cnt_one : '0;
    end else if (w_hit && (r_match_count != c_cnt_max)) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end

  assign match_count = r_match_count;
`else
  logic w_unused_count_clr;

  assign w_unused_count_clr = count_clr;
  assign match_count        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_detect
// Description : Scoreboard bench for seq_detect (101/CNT_W=8, 101/CNT_W=2,
//               A5/PAT_LEN=8 instances sharing one stimulus bus).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       overlap = 1'b0;
  logic       count_clr = 1'b0;
  logic       y_a, y_b, y_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_c;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int    d;
    logic  ey;
    int    ecnt;
    string nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  seq_detect #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .count_clr(count_clr), .y(y_a), .match_count(cnt_a)
  );

  seq_detect #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .count_clr(count_clr), .y(y_b), .match_count(cnt_b)
  );

  seq_detect #(.PAT_LEN(8), .PATTERN(8'hA5), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .count_clr(count_clr), .y(y_c), .match_count(cnt_c)
  );

  // Counter is tied to zero unless the count feature is compiled in.
  function automatic int ec(input int v);
`ifdef SEQ_DETECT_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string nm, input int ay, input int ey,
                       input int ac, input int ecnt);
    compared++;
    if (ay != ey || ac != ecnt) begin
      mismatched++;
      $display("FAIL %s: got y=%0d count=%0d, expected y=%0d count=%0d",
               nm, ay, ac, ey, ecnt);
    end
  endtask

  // Monitor: everything queued before an edge is checked just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        mon_e = q.pop_front();
        case (mon_e.d)
          0:       check(mon_e.nm, int'(y_a), int'(mon_e.ey), int'(cnt_a), mon_e.ecnt);
          1:       check(mon_e.nm, int'(y_b), int'(mon_e.ey), int'(cnt_b), mon_e.ecnt);
          default: check(mon_e.nm, int'(y_c), int'(mon_e.ey), int'(cnt_c), mon_e.ecnt);
        endcase
      end
    end
  end

  task automatic exp_push(input int d, input logic ey, input int ecnt, input string nm);
    exp_t e;
    e.d = d; e.ey = ey; e.ecnt = ec(ecnt); e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input int d, input logic e, input logic xi, input logic ov,
                      input logic clr, input logic ey, input int ecnt, input string nm);
    en = e; x = xi; overlap = ov; count_clr = clr;
    exp_push(d, ey, ecnt, nm);
    tick();
  endtask

  task automatic s(input int d, input logic xi, input logic ov, input logic ey,
                   input int ecnt, input string nm);
    step(d, 1'b1, xi, ov, 1'b0, ey, ecnt, nm);
  endtask

  task automatic do_reset(input string nm);
    en = 1'b0; x = 1'b0; overlap = 1'b0; count_clr = 1'b0;
    reset = 1'b1;
    exp_push(0, 1'b0, 0, {nm, "_a"});
    exp_push(1, 1'b0, 0, {nm, "_b"});
    exp_push(2, 1'b0, 0, {nm, "_c"});
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] stream;
    @(negedge clk);

    // Basic 0,1,0,1,0 with overlap
    do_reset("rst0");
    s(0, 1'b0, 1'b1, 1'b0, 0, "basic0");
    s(0, 1'b1, 1'b1, 1'b0, 0, "basic1");
    s(0, 1'b0, 1'b1, 1'b0, 0, "basic2");
    s(0, 1'b1, 1'b1, 1'b1, 1, "basic3");
    s(0, 1'b0, 1'b1, 1'b0, 1, "basic4");

    // Overlapping 1,0,1,0,1
    do_reset("rst1");
    s(0, 1'b1, 1'b1, 1'b0, 0, "ovl0");
    s(0, 1'b0, 1'b1, 1'b0, 0, "ovl1");
    s(0, 1'b1, 1'b1, 1'b1, 1, "ovl2");
    s(0, 1'b0, 1'b1, 1'b0, 1, "ovl3");
    s(0, 1'b1, 1'b1, 1'b1, 2, "ovl4");

    // Same stream, non-overlapping
    do_reset("rst2");
    s(0, 1'b1, 1'b0, 1'b0, 0, "novl0");
    s(0, 1'b0, 1'b0, 1'b0, 0, "novl1");
    s(0, 1'b1, 1'b0, 1'b1, 1, "novl2");
    s(0, 1'b0, 1'b0, 1'b0, 1, "novl3");
    s(0, 1'b1, 1'b0, 1'b0, 1, "novl4");

    // Stall: history held, y never stretched
    do_reset("rst3");
    s(0, 1'b1, 1'b1, 1'b0, 0, "stall0");
    s(0, 1'b0, 1'b1, 1'b0, 0, "stall1");
    for (int i = 0; i < 3; i++)
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, $sformatf("stall_off%0d", i));
    s(0, 1'b1, 1'b1, 1'b1, 1, "stall_hit");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, "stall_drop");
    s(0, 1'b0, 1'b1, 1'b0, 1, "stall2");
    s(0, 1'b1, 1'b1, 1'b1, 2, "stall_hit2");

    // Reset mid-pattern
    do_reset("rst4");
    s(0, 1'b1, 1'b1, 1'b0, 0, "mid0");
    s(0, 1'b0, 1'b1, 1'b0, 0, "mid1");
    do_reset("rst5");
    s(0, 1'b1, 1'b1, 1'b0, 0, "mid_nohit");
    s(0, 1'b0, 1'b1, 1'b0, 0, "mid2");
    s(0, 1'b1, 1'b1, 1'b1, 1, "mid_hit");

    // Overlap switched on just before the hit keeps the history
    do_reset("rst6");
    s(0, 1'b1, 1'b0, 1'b0, 0, "osw0");
    s(0, 1'b0, 1'b0, 1'b0, 0, "osw1");
    s(0, 1'b1, 1'b1, 1'b1, 1, "osw_hit1");
    s(0, 1'b0, 1'b1, 1'b0, 1, "osw2");
    s(0, 1'b1, 1'b1, 1'b1, 2, "osw_hit2");

    // Reset takes effect without a clock edge
    reset = 1'b1;
    #1;
    check("async_rst", int'(y_a), 0, int'(cnt_a), 0);
    @(negedge clk);

    // Saturation (CNT_W=2) and clear
    do_reset("rst7");
    for (int i = 0; i < 11; i++)
      s(1, (i % 2 == 0), 1'b1, (i >= 2 && i % 2 == 0),
        (i < 2) ? 0 : ((i / 2 > 3) ? 3 : i / 2), $sformatf("sat%0d", i));
    s(1, 1'b0, 1'b1, 1'b0, 3, "sat_hold");
    step(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, "clr_hit");
    step(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "clr_nohit");
    step(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "clr_idle");

    // Generic pattern A5 twice, non-overlapping
    do_reset("rst8");
    stream = 16'hA5A5;
    for (int i = 0; i < 16; i++)
      s(2, stream[15-i], 1'b0, (i == 7 || i == 15),
        (i >= 15) ? 2 : ((i >= 7) ? 1 : 0), $sformatf("a5_%0d", i));

    tick();
    tick();
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/seq_detect.md
# seq_detect

Parametrised serial pattern detector, the general successor to the fixed three-bit Moore "101" detector in the FSM library. It samples one bit per enabled clock and compares the last PAT_LEN bits against a compile-time pattern. It pulses a registered, Moore-style match flag and can optionally count matches. It sits between a bit-serial source and control logic that needs framing, sync-word or sequence events.

## Interface
- PAT_LEN, default 3: pattern length in bits, legal range 2..16.
- PATTERN, default 3'b101: pattern, PAT_LEN bits wide; the MSB is the first bit received.
- CNT_W, default 8: match counter width, legal range 1..16; used only when the count feature is built in.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  bit valid; x is sampled only when en=1.
- x  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every enabled cycle.
- count_clr  input  1  synchronous clear of the match counter.
- y  output  1  match pulse, registered.
- match_count  output  CNT_W  saturating number of matches since reset or clear.

## Operation
- State:
  - shift register sr[PAT_LEN-1:0].
  - fill counter fill, range 0..PAT_LEN, saturating; counts valid history bits.
  - y register.
  - match_count register.
- Enabled cycle (en=1):
  - nxt = {sr[PAT_LEN-2:0], x}.
  - hit = (fill >= PAT_LEN-1) and (nxt == PATTERN).
  - sr <= nxt.
  - y <= hit.
- Fill update when hit=1:
  - overlap=1: fill <= PAT_LEN, so the history is kept and overlapping matches are found.
  - overlap=0: fill <= 0, so the next match needs PAT_LEN fresh bits.
- Fill update when hit=0: fill <= min(fill+1, PAT_LEN).
- Disabled cycle (en=0):
  - sr and fill hold.
  - y <= 0, so a match pulse never stretches across stalls.
- An overlap change takes effect on the next enabled hit; it never discards the current history.
- No partial-pattern matching: bits shifted in before reset completes are never part of a match.
- Counter:
  - count_clr=1 forces match_count <= 0, or to 1 if hit=1 in the same cycle.
  - Otherwise, each hit increments match_count, saturating at 2^CNT_W-1 with no wrap.
- Reset (asynchronous, at any time, including mid-pattern):
  - sr = 0, fill = 0, y = 0, match_count = 0.
  - History is lost; the first possible match is on the PAT_LEN-th enabled bit after reset deasserts.

## Timing
- Latency: y rises in the cycle after the clock edge that sampled the final pattern bit. It is high for exactly one cycle per hit.
- Back-to-back matches, when overlap=1 and the pattern is self-overlapping, give y high on consecutive or near-consecutive cycles with no dead cycle inserted.
- match_count updates on the same edge as y, so both reflect the same hit.
- Outputs are purely registered; there is no combinational path from x, en or overlap to y.
- Reset deassertion is not internally synchronised; the integrator supplies a reset synchronised to clk.

## Configuration
- SEQ_DETECT_COUNT_EN defined:
  - match counter and count_clr logic are built in.
  - match_count behaves as described above.
- SEQ_DETECT_COUNT_EN undefined:
  - counter logic is removed.
  - match_count is tied to 0.
  - count_clr is ignored.
  - y behaviour is identical in both builds.

## Test plan
All scenarios use PAT_LEN=3, PATTERN=101, CNT_W=8 and the count feature enabled unless stated otherwise.
- Basic: reset, en=1, overlap=1, x=0,1,0,1,0 -> y=1 for one cycle, one cycle after the 4th bit; match_count=1.
- Overlap: x=1,0,1,0,1 -> overlap=1 gives two y pulses (count 2); overlap=0 gives one pulse (count 1).
- Stall: x=1,0 then en=0 for 3 cycles, then x=1 with en=1 -> y stays 0 through the stall and pulses once after the final 1.
- Reset mid-pattern: x=1,0, assert reset, release, then x=1 -> no pulse; x=0,1 next -> pulse.
- Saturation and clear: CNT_W=2, five matches -> match_count=3; count_clr=1 coincident with a hit -> match_count=1.
- Generic pattern: PAT_LEN=8, PATTERN=8'hA5, stream 0xA5 then 0xA5 with overlap=0 -> exactly two pulses, 8 cycles apart. Build without SEQ_DETECT_COUNT_EN -> match_count stays 0 and y is unchanged.
